eth_rx_hdr_filter: RTL and testbench

//  Consumes the 64-bit AXI-Stream Ethernet frames that eth_stimulate (sim) or the MAC (hw) drives toward the FPGA.

---
 rtl/eth_pkg.sv | 39 +++
 rtl/eth_realign64.sv | 46 ++++
 rtl/eth_rx_hdr_filter.sv | 148 ++++++++++++++
 tb/tb_eth_rx_hdr_filter.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_pkg.sv
// Shared types and helpers for the Ethernet receive header filter.
package eth_pkg;

  localparam int ETH_HDR_BYTES = 14;
  // Header bytes that spill into beat1 leave this many payload bytes behind per beat.
  localparam int RES_BYTES = 2 * 8 - ETH_HDR_BYTES;
  localparam logic [47:0] BCAST_MAC = 48'hffffffffffff;

  typedef struct packed {
    logic [47:0] dst;
    logic [47:0] src;
    logic [15:0] etype;
  } eth_hdr_t;

  typedef enum logic [2:0] {
    HDR0  = 3'd0,
    HDR1  = 3'd1,
    PASS  = 3'd2,
    FLUSH = 3'd3,
    DROP  = 3'd4
  } rx_state_e;

  function automatic logic [63:0] keep_mask(input logic [7:0] keep);
    logic [63:0] m;
    m = 64'd0;
    for (int i = 0; i < 8; i++) m[8*i +: 8] = {8{keep[i]}};
    return m;
  endfunction

  // Wire byte 0 is the most significant byte of every header field.
  function automatic eth_hdr_t parse_hdr(input logic [63:0] b0, input logic [63:0] b1);
    eth_hdr_t h;
    h.dst   = {b0[7:0], b0[15:8], b0[23:16], b0[31:24], b0[39:32], b0[47:40]};
    h.src   = {b0[55:48], b0[63:56], b1[7:0], b1[15:8], b1[23:16], b1[31:24]};
    h.etype = {b1[39:32], b1[47:40]};
    return h;
  endfunction

endpackage

// File: rtl/eth_realign64.sv
// Payload re-alignment: carries the trailing bytes of each beat into the next output beat.
module eth_realign64
  import eth_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_hdr,
  input  logic        shift,
  input  logic [63:0] in_data,
  input  logic [7:0]  in_keep,
  output logic [63:0] merge_data,
  output logic [7:0]  merge_keep,
  output logic [63:0] flush_data,
  output logic [7:0]  flush_keep
);

  logic [8*RES_BYTES-1:0] residue;
  logic [RES_BYTES-1:0]   res_keep;
  logic [63:0]            in_masked;

  always_comb begin
    in_masked  = in_data & keep_mask(in_keep);
    merge_data = {in_masked[63-8*RES_BYTES:0], residue};
    merge_keep = {in_keep[7-RES_BYTES:0], {RES_BYTES{1'b1}}};
    flush_data = {{(64 - 8*RES_BYTES){1'b0}}, residue};
    flush_keep = {{(8 - RES_BYTES){1'b0}}, res_keep};
  end

  // Residue is stored already masked so a flush never exposes stale bytes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      residue  <= '0;
      res_keep <= '0;
    end else if (load_hdr) begin
      residue  <= in_data[63:64-8*RES_BYTES];
      res_keep <= {RES_BYTES{1'b1}};
    end else if (shift) begin
      residue  <= in_masked[63:64-8*RES_BYTES];
      res_keep <= in_keep[7:8-RES_BYTES];
    end else begin
      residue  <= residue;
      res_keep <= res_keep;
    end
  end

endmodule

// File: rtl/eth_rx_hdr_filter.sv
// Ethernet RX header filter: MAC/ethertype check, runt drop, header strip with payload re-alignment.
module eth_rx_hdr_filter
  import eth_pkg::*;
#(
  parameter logic [47:0] MAC_ADDR     = 48'hfa163e55ca02,
  parameter bit          ACCEPT_BCAST = 1'b1,
  parameter bit          ETYPE_CHECK  = 1'b0,
  parameter logic [15:0] ETYPE        = 16'h0800
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [63:0] stream_in_DATA,
  input  logic [7:0]  stream_in_KEEP,
  input  logic        stream_in_LAST,
  input  logic        stream_in_VALID,
  output logic        stream_in_READY,
  output logic [63:0] stream_out_DATA,
  output logic [7:0]  stream_out_KEEP,
  output logic        stream_out_LAST,
  output logic        stream_out_VALID,
  input  logic        stream_out_READY,
  output logic [47:0] src_mac,
  output logic [15:0] eth_type,
  output logic [31:0] cnt_pass,
  output logic [31:0] cnt_drop
);

  rx_state_e   state;
  logic [63:0] beat0;
  eth_hdr_t    hdr;
  logic        hdr_ok;
  logic        in_hs;
  logic        out_hs;
  logic        out_free;
  logic        load_hdr;
  logic        shift;
  logic [63:0] merge_data;
  logic [7:0]  merge_keep;
  logic [63:0] flush_data;
  logic [7:0]  flush_keep;

  always_comb begin
    out_free = !stream_out_VALID || stream_out_READY;
    out_hs   = stream_out_VALID && stream_out_READY;
    in_hs    = stream_in_VALID && stream_in_READY;
    hdr      = parse_hdr(beat0, stream_in_DATA);
    hdr_ok   = ((hdr.dst == MAC_ADDR) || (ACCEPT_BCAST && (hdr.dst == BCAST_MAC)))
               && (!ETYPE_CHECK || (hdr.etype == ETYPE));
    load_hdr = in_hs && (state == HDR1) && !stream_in_LAST && hdr_ok;
    shift    = in_hs && (state == PASS);
  end

  // HDR1 waits for the previous frame's last beat to leave so the sideband never changes under it.
  always_comb begin
    stream_in_READY = 1'b0;
    case (state)
      HDR0, DROP: stream_in_READY = 1'b1;
      HDR1, PASS: stream_in_READY = out_free;
      FLUSH:      stream_in_READY = 1'b0;
      default:    stream_in_READY = 1'b0;
    endcase
  end

  eth_realign64 u_realign (
    .clk        (aclk),
    .rst_n      (aresetn),
    .load_hdr   (load_hdr),
    .shift      (shift),
    .in_data    (stream_in_DATA),
    .in_keep    (stream_in_KEEP),
    .merge_data (merge_data),
    .merge_keep (merge_keep),
    .flush_data (flush_data),
    .flush_keep (flush_keep)
  );

  // Frame FSM, output register stage, sideband and counters.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state            <= HDR0;
      beat0            <= 64'd0;
      stream_out_DATA  <= 64'd0;
      stream_out_KEEP  <= 8'd0;
      stream_out_LAST  <= 1'b0;
      stream_out_VALID <= 1'b0;
      src_mac          <= 48'd0;
      eth_type         <= 16'd0;
      cnt_pass         <= 32'd0;
      cnt_drop         <= 32'd0;
    end else begin
      if (out_hs) begin
        stream_out_VALID <= 1'b0;
        if (stream_out_LAST) cnt_pass <= cnt_pass + 32'd1;
      end

      case (state)
        HDR0: begin
          if (in_hs) begin
            beat0 <= stream_in_DATA;
            if (stream_in_LAST) cnt_drop <= cnt_drop + 32'd1;
            else                state    <= HDR1;
          end
        end
        HDR1: begin
          if (in_hs) begin
            if (stream_in_LAST) begin
              cnt_drop <= cnt_drop + 32'd1;
              state    <= HDR0;
            end else if (hdr_ok) begin
              src_mac  <= hdr.src;
              eth_type <= hdr.etype;
              state    <= PASS;
            end else begin
              state <= DROP;
            end
          end
        end
        PASS: begin
          if (in_hs) begin
            stream_out_VALID <= 1'b1;
            stream_out_DATA  <= merge_data;
            stream_out_KEEP  <= merge_keep;
            // Seven or more bytes in the last beat leave residue that needs its own beat.
            stream_out_LAST  <= stream_in_LAST && !stream_in_KEEP[6];
            if (stream_in_LAST) state <= stream_in_KEEP[6] ? FLUSH : HDR0;
          end
        end
        FLUSH: begin
          if (out_free) begin
            stream_out_VALID <= 1'b1;
            stream_out_DATA  <= flush_data;
            stream_out_KEEP  <= flush_keep;
            stream_out_LAST  <= 1'b1;
            state            <= HDR0;
          end
        end
        DROP: begin
          if (in_hs && stream_in_LAST) begin
            cnt_drop <= cnt_drop + 32'd1;
            state    <= HDR0;
          end
        end
        default: state <= HDR0;
      endcase
    end
  end

endmodule

// File: tb/tb_eth_rx_hdr_filter.sv
// Randomized scoreboard bench for eth_rx_hdr_filter with a byte-level frame reference model.
module tb_eth_rx_hdr_filter;

  localparam logic [47:0] OWN_MAC = 48'hfa163e55ca02;
  localparam logic [47:0] BC_MAC  = 48'hffffffffffff;

  typedef struct {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
    logic [47:0] src;
    logic [15:0] et;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] in_data = 64'd0;
  logic [7:0]  in_keep = 8'd0;
  logic        in_last = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] out_data;
  logic [7:0]  out_keep;
  logic        out_last;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [47:0] src_mac;
  logic [15:0] eth_type;
  logic [31:0] cnt_pass;
  logic [31:0] cnt_drop;

  beat_t exp_q[$];
  int    checks = 0;
  int    failures = 0;
  int    exp_pass = 0;
  int    exp_drop = 0;
  int    stalls = 0;
  int    out_beats = 0;
  bit    rand_rdy = 1'b0;

  eth_rx_hdr_filter dut (
    .aclk             (clk),
    .aresetn          (rst_n),
    .stream_in_DATA   (in_data),
    .stream_in_KEEP   (in_keep),
    .stream_in_LAST   (in_last),
    .stream_in_VALID  (in_valid),
    .stream_in_READY  (in_ready),
    .stream_out_DATA  (out_data),
    .stream_out_KEEP  (out_keep),
    .stream_out_LAST  (out_last),
    .stream_out_VALID (out_valid),
    .stream_out_READY (out_ready),
    .src_mac          (src_mac),
    .eth_type         (eth_type),
    .cnt_pass         (cnt_pass),
    .cnt_drop         (cnt_drop)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference model: whole-frame rules on a byte list.
  task automatic model_frame(input logic [7:0] f[$]);
    logic [47:0] dst, src;
    logic [15:0] et;
    beat_t b;
    if (f.size() <= 16) begin
      exp_drop++;
      return;
    end
    dst = 48'd0;
    src = 48'd0;
    for (int i = 0; i < 6; i++) begin
      dst = {dst[39:0], f[i]};
      src = {src[39:0], f[6+i]};
    end
    et = {f[12], f[13]};
    if (dst != OWN_MAC && dst != BC_MAC) begin
      exp_drop++;
      return;
    end
    for (int p = 14; p < f.size(); p += 8) begin
      b.d = 64'd0;
      b.k = 8'd0;
      for (int j = 0; j < 8; j++) begin
        if (p + j < f.size()) begin
          b.d[8*j +: 8] = f[p+j];
          b.k[j] = 1'b1;
        end
      end
      b.l   = (p + 8 >= f.size());
      b.src = src;
      b.et  = et;
      exp_q.push_back(b);
    end
    exp_pass++;
  endtask

  task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic l);
    int  t;
    logic hs;
    t = 0;
    in_data = d;
    in_keep = k;
    in_last = l;
    in_valid = 1'b1;
    do begin
      @(negedge clk);
      hs = in_ready;
      if (!hs) stalls++;
      @(posedge clk);
      #1;
      t++;
    end while (!hs && t < 2000);
    if (!hs) begin
      checks++;
      failures++;
      $display("FAIL in_ready_timeout actual=0 expected=1");
    end
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] f[$], input int max_beats);
    int nb;
    logic [63:0] d;
    logic [7:0] k;
    nb = (f.size() + 7) / 8;
    for (int b = 0; b < nb && b < max_beats; b++) begin
      d = {$urandom, $urandom};
      k = 8'd0;
      for (int j = 0; j < 8; j++) begin
        if (8*b + j < f.size()) begin
          d[8*j +: 8] = f[8*b+j];
          k[j] = 1'b1;
        end
      end
      send_beat(d, k, (b == nb - 1));
    end
  endtask

  function automatic void make_frame(input logic [47:0] dst, input logic [47:0] src,
                                     input logic [15:0] et, input int plen,
                                     output logic [7:0] f[$]);
    f = {};
    for (int i = 0; i < 6; i++) f.push_back(dst[47-8*i -: 8]);
    for (int i = 0; i < 6; i++) f.push_back(src[47-8*i -: 8]);
    f.push_back(et[15:8]);
    f.push_back(et[7:0]);
    for (int i = 0; i < plen; i++) f.push_back(8'($urandom));
  endfunction

  task automatic wait_idle(input string name);
    int t;
    t = 0;
    while ((exp_q.size() != 0 || out_valid) && t < 5000) begin
      @(posedge clk);
      #1;
      t++;
    end
    checks++;
    if (t >= 5000) begin
      failures++;
      $display("FAIL %s_drain actual=%0d expected=0", name, exp_q.size());
    end
    repeat (2) @(posedge clk);
    #1;
    chk({name, "_cnt_pass"}, 64'(cnt_pass), 64'(exp_pass));
    chk({name, "_cnt_drop"}, 64'(cnt_drop), 64'(exp_drop));
  endtask

  // Output backpressure driver.
  initial forever begin
    @(posedge clk);
    #1;
    out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor: pops one expected beat per output handshake.
  initial forever begin
    beat_t e;
    @(negedge clk);
    if (rst_n && out_valid && out_ready) begin
      out_beats++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_out_beat actual=%h expected=none", out_data);
      end else begin
        e = exp_q.pop_front();
        chk("out_data", out_data, e.d);
        chk("out_keep", 64'(out_keep), 64'(e.k));
        chk("out_last", 64'(out_last), 64'(e.l));
        chk("src_mac", 64'(src_mac), 64'(e.src));
        chk("eth_type", 64'(eth_type), 64'(e.et));
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check_reset_state(input string name);
    chk({name, "_out_valid"}, 64'(out_valid), 64'd0);
    chk({name, "_out_data"}, out_data, 64'd0);
    chk({name, "_out_keep"}, 64'(out_keep), 64'd0);
    chk({name, "_out_last"}, 64'(out_last), 64'd0);
    chk({name, "_src_mac"}, 64'(src_mac), 64'd0);
    chk({name, "_eth_type"}, 64'(eth_type), 64'd0);
    chk({name, "_cnt_pass"}, 64'(cnt_pass), 64'd0);
    chk({name, "_cnt_drop"}, 64'(cnt_drop), 64'd0);
    chk({name, "_in_ready"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    logic [7:0] f[$];
    logic [63:0] b0, b1, b2;
    int s0, o0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_state("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed frame given as raw beats.
    b0 = 64'hc40c02ca553e16fa;
    b1 = 64'h0100000100030000;
    b2 = 64'h5073930200000000;
    f = {};
    for (int i = 0; i < 8; i++) f.push_back(b0[8*i +: 8]);
    for (int i = 0; i < 8; i++) f.push_back(b1[8*i +: 8]);
    for (int i = 0; i < 4; i++) f.push_back(b2[8*i +: 8]);
    model_frame(f);
    send_frame(f, 99);
    wait_idle("t1");

    // Same frame with a foreign dst: dropped without backpressure.
    for (int i = 0; i < 6; i++) f[i] = 8'(8'h11 * (i + 1));
    model_frame(f);
    s0 = stalls;
    o0 = out_beats;
    send_frame(f, 99);
    wait_idle("t2");
    chk("t2_ready_stalls", 64'(stalls - s0), 64'd0);
    chk("t2_out_beats", 64'(out_beats - o0), 64'd0);

    // Broadcast, full last beat: FLUSH beat needed.
    make_frame(BC_MAC, 48'h0a0b0c0d0e0f, 16'h0800, 34, f);
    model_frame(f);
    o0 = out_beats;
    send_frame(f, 99);
    wait_idle("t3");
    chk("t3_out_beats", 64'(out_beats - o0), 64'd5);

    // Runts, then a good frame.
    make_frame(OWN_MAC, 48'h123456789abc, 16'h86dd, 0, f);
    void'(f.pop_back()); void'(f.pop_back()); void'(f.pop_back());
    void'(f.pop_back()); void'(f.pop_back()); void'(f.pop_back());
    model_frame(f);
    send_frame(f, 99);
    make_frame(OWN_MAC, 48'h123456789abc, 16'h86dd, 0, f);
    model_frame(f);
    send_frame(f, 99);
    make_frame(OWN_MAC, 48'h123456789abc, 16'h86dd, 21, f);
    model_frame(f);
    send_frame(f, 99);
    wait_idle("t4");

    // Random frames with random output backpressure.
    rand_rdy = 1'b1;
    for (int n = 0; n < 100; n++) begin
      logic [47:0] dst;
      case ($urandom_range(0, 3))
        0, 1:    dst = OWN_MAC;
        2:       dst = BC_MAC;
        default: dst = {$urandom, $urandom};
      endcase
      make_frame(dst, {$urandom, $urandom}, 16'($urandom), $urandom_range(0, 60), f);
      if ($urandom_range(0, 7) == 0) void'(f.pop_back());
      model_frame(f);
      send_frame(f, 99);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    wait_idle("t5");
    rand_rdy = 1'b0;

    // Asynchronous reset in the middle of a forwarded frame.
    make_frame(OWN_MAC, 48'h665544332211, 16'h0800, 40, f);
    model_frame(f);
    send_frame(f, 4);
    rst_n = 1'b0;
    @(negedge clk);
    exp_q.delete();
    exp_pass = 0;
    exp_drop = 0;
    check_reset_state("t6_reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    make_frame(OWN_MAC, 48'h0cc47a88c047, 16'h0300, 13, f);
    model_frame(f);
    send_frame(f, 99);
    wait_idle("t6");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
